// File: rtl/menu_pkg.sv
// Shared definitions for the menu/mode controller.
//   menu_state_t : menu FSM state encoding (MAIN, FUNCTION, DISPLAY, SETTINGS)
//   MAIN_ITEMS   : number of selectable entries in the MAIN menu
//   cur_w()      : cursor width needed to address items 0..max(nf,nm), where
//                  the top value is the BACK entry of a sub-menu
package menu_pkg;

    typedef enum logic [1:0] {
        MAIN     = 2'd0,
        FUNCTION = 2'd1,
        DISPLAY  = 2'd2,
        SETTINGS = 2'd3
    } menu_state_t;

    localparam int MAIN_ITEMS = 3;

    function automatic int cur_w(input int nf, input int nm);
        int mx;
        mx = (nf > nm) ? nf : nm;
        return $clog2(mx + 1);
    endfunction

endpackage

// File: rtl/menu_mode_controller_if.sv
// Bus between the key/encoder debouncers and the menu/mode controller.
//   master : debouncer side, drives key_pulse / enc_* pulses, observes config
//   slave  : controller side, consumes pulses, drives the configuration outputs
// Outputs: func_enable, display_mode, menu_state, menu_cursor, setting_val,
//          cfg_changed (one-cycle pulse on any configuration value change).
interface menu_mode_controller_if
    import menu_pkg::*;
#(
    parameter int NUM_FUNC  = 8,
    parameter int NUM_MODES = 4,
    parameter int SET_W     = 4
);
    localparam int KEY_W  = NUM_FUNC + NUM_MODES;
    localparam int MODE_W = $clog2(NUM_MODES);
    localparam int CUR_W  = cur_w(NUM_FUNC, NUM_MODES);

    logic [KEY_W-1:0]    key_pulse;
    logic                enc_cw;
    logic                enc_ccw;
    logic                enc_press;
    logic [NUM_FUNC-1:0] func_enable;
    logic [MODE_W-1:0]   display_mode;
    logic [1:0]          menu_state;
    logic [CUR_W-1:0]    menu_cursor;
    logic [SET_W-1:0]    setting_val;
    logic                cfg_changed;

    modport master (
        output key_pulse, enc_cw, enc_ccw, enc_press,
        input  func_enable, display_mode, menu_state, menu_cursor,
               setting_val, cfg_changed
    );

    modport slave (
        input  key_pulse, enc_cw, enc_ccw, enc_press,
        output func_enable, display_mode, menu_state, menu_cursor,
               setting_val, cfg_changed
    );

endinterface

// File: rtl/menu_idle_timer.sv
// Menu inactivity timer.
//   clk, rst : clock and synchronous active-high reset
//   clear    : restart the idle count (activity, or menu is at MAIN)
//   run      : count while high and not cleared
//   expire   : one-cycle pulse in the cycle the count sits at TIMEOUT_CYC-1;
//              the count wraps to zero on the same edge
module menu_idle_timer #(
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expire
);
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    // Combinational so the FSM can fall back to MAIN on the edge that ends
    // the TIMEOUT_CYC-th idle cycle.
    assign expire = run && !clear && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= expire ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/menu_mode_controller.sv
// Menu/mode controller: owns the function-enable mask, display mode and one
// adjustable setting, navigated by a rotary encoder menu with an inactivity
// timeout; direct keys can toggle functions or pick modes at any time.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of menu_mode_controller_if (key/encoder pulses in,
//              registered configuration and menu status out)
module menu_mode_controller
    import menu_pkg::*;
#(
    parameter int NUM_FUNC    = 8,
    parameter int NUM_MODES   = 4,
    parameter int SET_W       = 4,
    parameter int SET_MAX     = 15,
    parameter int SET_INIT    = 8,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input logic                    clk,
    input logic                    rst,
    menu_mode_controller_if.slave  bus
);
    localparam int MODE_W = $clog2(NUM_MODES);
    localparam int CUR_W  = cur_w(NUM_FUNC, NUM_MODES);

    localparam logic [CUR_W-1:0] MAIN_LAST = CUR_W'(MAIN_ITEMS - 1);
    localparam logic [CUR_W-1:0] FUNC_BACK = CUR_W'(NUM_FUNC);
    localparam logic [CUR_W-1:0] MODE_BACK = CUR_W'(NUM_MODES);
    localparam logic [SET_W-1:0] SET_CEIL  = SET_W'(SET_MAX);
    localparam logic [SET_W-1:0] SET_RST   = SET_W'(SET_INIT);

    menu_state_t         state, state_n;
    logic [CUR_W-1:0]    cursor, cursor_n;
    logic [NUM_FUNC-1:0] func_q, func_n, menu_tog;
    logic [MODE_W-1:0]   mode_q, mode_n, key_mode;
    logic [SET_W-1:0]    set_q, set_n;
    logic                cfg_chg_q, cfg_chg_n;
    logic                key_mode_vld, menu_mode_vld;
    logic                cw, ccw, press, expire, idle_clear;

    // Opposite rotations cancel; a press wins over any rotation.
    assign press = bus.enc_press;
    assign cw    = bus.enc_cw  && !bus.enc_ccw && !bus.enc_press;
    assign ccw   = bus.enc_ccw && !bus.enc_cw  && !bus.enc_press;

    assign idle_clear = bus.enc_cw || bus.enc_ccw || bus.enc_press || (state == MAIN);

    menu_idle_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_idle (
        .clk    (clk),
        .rst    (rst),
        .clear  (idle_clear),
        .run    (state != MAIN),
        .expire (expire)
    );

    function automatic logic [CUR_W-1:0] wrap_inc(input logic [CUR_W-1:0] c,
                                                  input logic [CUR_W-1:0] last);
        return (c == last) ? '0 : c + 1'b1;
    endfunction

    function automatic logic [CUR_W-1:0] wrap_dec(input logic [CUR_W-1:0] c,
                                                  input logic [CUR_W-1:0] last);
        return (c == '0) ? last : c - 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MAIN;
            cursor    <= '0;
            func_q    <= '1;
            mode_q    <= '0;
            set_q     <= SET_RST;
            cfg_chg_q <= 1'b0;
        end else begin
            state     <= state_n;
            cursor    <= cursor_n;
            func_q    <= func_n;
            mode_q    <= mode_n;
            set_q     <= set_n;
            cfg_chg_q <= cfg_chg_n;
        end
    end

    always_comb begin
        state_n       = state;
        cursor_n      = cursor;
        set_n         = set_q;
        menu_tog      = '0;
        menu_mode_vld = 1'b0;
        key_mode      = '0;
        key_mode_vld  = 1'b0;

        if (expire) begin
            state_n  = MAIN;
            cursor_n = '0;
        end else begin
            unique case (state)
                MAIN: begin
                    if (press) begin
                        cursor_n = '0;
                        unique case (cursor)
                            CUR_W'(0): state_n = FUNCTION;
                            CUR_W'(1): state_n = DISPLAY;
                            default:   state_n = SETTINGS;
                        endcase
                    end else if (cw) begin
                        cursor_n = wrap_inc(cursor, MAIN_LAST);
                    end else if (ccw) begin
                        cursor_n = wrap_dec(cursor, MAIN_LAST);
                    end
                end
                FUNCTION: begin
                    if (press) begin
                        if (cursor == FUNC_BACK) begin
                            state_n  = MAIN;
                            cursor_n = '0;
                        end else begin
                            for (int f = 0; f < NUM_FUNC; f++)
                                menu_tog[f] = (cursor == CUR_W'(f));
                        end
                    end else if (cw) begin
                        cursor_n = wrap_inc(cursor, FUNC_BACK);
                    end else if (ccw) begin
                        cursor_n = wrap_dec(cursor, FUNC_BACK);
                    end
                end
                DISPLAY: begin
                    if (press) begin
                        if (cursor == MODE_BACK) begin
                            state_n  = MAIN;
                            cursor_n = '0;
                        end else begin
                            menu_mode_vld = 1'b1;
                        end
                    end else if (cw) begin
                        cursor_n = wrap_inc(cursor, MODE_BACK);
                    end else if (ccw) begin
                        cursor_n = wrap_dec(cursor, MODE_BACK);
                    end
                end
                SETTINGS: begin
                    cursor_n = '0;
                    if (press) begin
                        state_n = MAIN;
                    end else if (cw) begin
                        set_n = (set_q >= SET_CEIL) ? SET_CEIL : set_q + 1'b1;
                    end else if (ccw) begin
                        set_n = (set_q == '0) ? '0 : set_q - 1'b1;
                    end
                end
                default: begin
                    state_n  = MAIN;
                    cursor_n = '0;
                end
            endcase
        end

        // OR before XOR so a key and a menu toggle on one bit flip it once.
        func_n = func_q ^ (bus.key_pulse[NUM_FUNC-1:0] | menu_tog);

        // Scan downwards so the lowest-index mode key is the one left standing.
        for (int m = NUM_MODES - 1; m >= 0; m--) begin
            if (bus.key_pulse[NUM_FUNC + m]) begin
                key_mode     = MODE_W'(m);
                key_mode_vld = 1'b1;
            end
        end

        if (key_mode_vld)
            mode_n = key_mode;
        else if (menu_mode_vld)
            mode_n = cursor[MODE_W-1:0];
        else
            mode_n = mode_q;

        cfg_chg_n = (func_n != func_q) || (mode_n != mode_q) || (set_n != set_q);
    end

    assign bus.func_enable  = func_q;
    assign bus.display_mode = mode_q;
    assign bus.menu_state   = state;
    assign bus.menu_cursor  = cursor;
    assign bus.setting_val  = set_q;
    assign bus.cfg_changed  = cfg_chg_q;

endmodule

// File: doc/menu_mode_controller.md
Name: menu_mode_controller

Overview:
- Parametrised successor to the key-driven mode controller.
- Owns the function-enable mask, the display mode, one adjustable setting value, and a rotary-encoder-navigated menu FSM with inactivity timeout.
- Direct key toggles stay available alongside menu navigation.
- Sits between the key/encoder debouncers and the FFT/SPL/BPM/lighting/display consumers.

Parameters:
- NUM_FUNC, 8, number of function-enable bits (1..16)
- NUM_MODES, 4, number of display modes (2..8)
- SET_W, 4, width of the setting value
- SET_MAX, 15, saturation ceiling of the setting value (must be ≤ 2^SET_W-1)
- SET_INIT, 8, reset value of the setting
- TIMEOUT_CYC, 50_000_000, idle cycles before the menu falls back to MAIN (must be ≥ 2)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- key_pulse  in  NUM_FUNC+NUM_MODES  one-cycle pulses; bit f toggles func f; bit NUM_FUNC+m selects mode m
- enc_cw  in  1  one-cycle clockwise detent pulse
- enc_ccw  in  1  one-cycle counter-clockwise detent pulse
- enc_press  in  1  one-cycle encoder button pulse
- func_enable  out  NUM_FUNC  function-enable mask
- display_mode  out  MODE_W=$clog2(NUM_MODES)  active display mode
- menu_state  out  2  current menu state (package encoding)
- menu_cursor  out  CUR_W=$clog2(max(NUM_FUNC,NUM_MODES)+1)  highlighted item
- setting_val  out  SET_W  adjustable setting value
- cfg_changed  out  1  one-cycle pulse in the cycle any of func_enable/display_mode/setting_val changes value

Behaviour:
- Reset (rst high at a clk edge; dominates every other input):
  - func_enable = all ones
  - display_mode = 0
  - menu_state = MAIN
  - menu_cursor = 0
  - setting_val = SET_INIT
  - cfg_changed = 0
  - idle counter cleared
  - A reset arriving mid-navigation discards the menu context.
- Timing: all outputs are registered. A pulse in cycle N is reflected in the outputs in cycle N+1; cfg_changed rises in that same N+1 cycle.
- Encoder qualification:
  - enc_cw and enc_ccw together: both ignored.
  - enc_press together with a rotation: press is processed, rotation is dropped.
- MAIN state:
  - Cursor ranges 0..2 (0=FUNCTION, 1=DISPLAY, 2=SETTINGS).
  - cw increments, ccw decrements, both wrapping (2→0, 0→2).
  - press enters the selected state with cursor = 0.
- FUNCTION state:
  - Cursor ranges 0..NUM_FUNC; the value NUM_FUNC is the BACK item. Rotation wraps.
  - press on item f toggles func_enable[f] and the state is unchanged.
  - press on BACK goes to MAIN with cursor = 0.
- DISPLAY state:
  - Cursor ranges 0..NUM_MODES, with NUM_MODES = BACK. Rotation wraps.
  - press on item m sets display_mode = m.
  - press on BACK goes to MAIN with cursor = 0.
- SETTINGS state:
  - Cursor is held at 0.
  - cw increments setting_val, saturating at SET_MAX; ccw decrements it, saturating at 0.
  - press goes to MAIN with cursor = 0.
- Timeout:
  - Idle counter clears on any enc_* pulse and while in MAIN.
  - Otherwise it increments each cycle. On reaching TIMEOUT_CYC-1, next cycle: state = MAIN, cursor = 0, counter cleared.
  - Timeout does not alter func_enable, display_mode or setting_val.
- Direct keys (independent of menu state):
  - key_pulse[f] toggles func_enable[f].
  - If a key toggle and a menu toggle hit the same bit in the same cycle, the bit toggles exactly once.
- Mode keys:
  - With multiple mode keys in one cycle, the lowest index wins.
  - A mode key overrides a same-cycle menu mode selection.
- Only a value change asserts cfg_changed. Selecting the current mode or saturating with no change does not.

Decomposition:
- Shared package (menu_pkg):
  - menu_state encoding: MAIN=0, FUNCTION=1, DISPLAY=2, SETTINGS=3
  - MAIN_ITEMS=3
  - helper function for CUR_W
- Sub-module menu_idle_timer:
  - Parameter: TIMEOUT_CYC.
  - Inputs: clk, rst, clear, run.
  - Output: one-cycle expire pulse.
- FSM, mask, mode and setting logic stay in the top module.

Test Plan:
- Reset with defaults → func_enable=8'hFF, display_mode=0, setting_val=8, menu_state=MAIN, cursor=0, cfg_changed=0.
- key_pulse=16'h0005 for one cycle → func_enable=8'hFA next cycle with one cfg_changed pulse. key_pulse=16'h0600 → display_mode=1 (lowest index wins).
- MAIN: ccw → cursor=2. press → SETTINGS. 10× cw → setting_val saturates at 15, cfg_changed only on the 7 changing steps. press → MAIN.
- Enter FUNCTION, cw×3, press together with key_pulse[3] → func_enable[3] toggles once. cw×5 reaches cursor=8 (BACK), press → MAIN, cursor=0.
- TIMEOUT_CYC=16: enter DISPLAY, cw once, then idle 16 cycles → menu_state=MAIN, cursor=0, display_mode unchanged. enc_cw+enc_ccw together in DISPLAY → cursor unchanged.
- Assert rst while in FUNCTION with cursor=4 and func_enable=8'h0F → all outputs return to reset values the following cycle.
